// File: rtl/Func.sv
// Shared function-field encoding for R-type instructions (MIPS funct field).
package Func;

   typedef enum logic [5:0] {
      FnSll   = 6'h00,
      FnMfhi  = 6'h10,
      FnMthi  = 6'h11,
      FnMflo  = 6'h12,
      FnMtlo  = 6'h13,
      FnMult  = 6'h18,
      FnMultu = 6'h19,
      FnDiv   = 6'h1a,
      FnDivu  = 6'h1b,
      FnAdd   = 6'h20
   } Func_t;

endpackage

// File: rtl/MulDiv.sv
// HI/LO multiply-divide unit: state encoding and arithmetic helpers.
package MulDiv;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDiv,
      StFix
   } muldiv_state_t;

   localparam int unsigned DivIters = 32;

   // Two's-complement magnitude when the operand is treated as signed.
   function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
      return (is_signed && x[31]) ? (~x + 32'd1) : x;
   endfunction

   // Full 64-bit product; sign-extending to 64 bits makes one multiplier serve both flavours.
   function automatic logic [63:0] product(input logic [31:0] a, input logic [31:0] b,
                                           input logic is_signed);
      logic [63:0] ext_a;
      logic [63:0] ext_b;
      ext_a = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
      ext_b = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
      return ext_a * ext_b;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit and subtract if it fits.
module div_step (
   input  logic [31:0] rem_i,
   input  logic [31:0] quo_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] rem_o,
   output logic [31:0] quo_o
);

   logic [32:0] shifted;
   logic [32:0] diff;
   logic        fits;

   // Partial remainder is always below the divisor, so the 33-bit shift never loses a bit.
   always_comb begin
      shifted = {rem_i, quo_i[31]};
      diff    = shifted - {1'b0, divisor_i};
      fits    = (shifted >= {1'b0, divisor_i});
      rem_o   = fits ? diff[31:0] : shifted[31:0];
      quo_o   = {quo_i[30:0], fits};
   end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: single-cycle multiply, 32-step restoring divide, MTHI/MTLO.
module muldiv_unit
   import Func::*;
   import MulDiv::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  Func_t       func,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   muldiv_state_t state_q, state_d;
   Func_t         func_q, func_d;
   logic [31:0]   op_a_q, op_a_d;
   logic [31:0]   op_b_q, op_b_d;
   logic [31:0]   rem_q, rem_d;
   logic [31:0]   quo_q, quo_d;
   logic [31:0]   dvsr_q, dvsr_d;
   logic [5:0]    count_q, count_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic          done_q, done_d;

   logic [31:0]   step_rem;
   logic [31:0]   step_quo;
   logic [63:0]   prod;
   logic          mul_signed;
   logic          div_signed;
   logic          in_signed;
   logic          neg_quo;
   logic          neg_rem;

   div_step u_div_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (dvsr_q),
      .rem_o     (step_rem),
      .quo_o     (step_quo)
   );

   // Sign handling derived from the latched operation and operands.
   always_comb begin
      mul_signed = (func_q == FnMult);
      div_signed = (func_q == FnDiv);
      in_signed  = (func == FnMult) || (func == FnDiv);
      prod       = product(op_a_q, op_b_q, mul_signed);
      neg_quo    = div_signed && (op_a_q[31] ^ op_b_q[31]);
      neg_rem    = div_signed && op_a_q[31];
   end

   // Next-state, operand latching and HI/LO write selection.
   always_comb begin
      state_d = state_q;
      func_d  = func_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvsr_d  = dvsr_q;
      count_d = count_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      if (flush) begin
         // Cancel wins over everything, including a same-cycle start.
         state_d = StIdle;
         count_d = 6'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  case (func)
                     FnMult, FnMultu: begin
                        func_d  = func;
                        op_a_d  = rs_val;
                        op_b_d  = rt_val;
                        state_d = StMul;
                     end
                     FnDiv, FnDivu: begin
                        func_d  = func;
                        op_a_d  = rs_val;
                        op_b_d  = rt_val;
                        rem_d   = 32'd0;
                        quo_d   = magnitude(rs_val, in_signed);
                        dvsr_d  = magnitude(rt_val, in_signed);
                        count_d = 6'd0;
                        state_d = StDiv;
                     end
                     FnMthi:  hi_d = rs_val;
                     FnMtlo:  lo_d = rs_val;
                     default: ;
                  endcase
               end
            end
            StMul: begin
               hi_d    = prod[63:32];
               lo_d    = prod[31:0];
               done_d  = 1'b1;
               state_d = StIdle;
            end
            StDiv: begin
               rem_d   = step_rem;
               quo_d   = step_quo;
               count_d = count_q + 6'd1;
               if (count_q == 6'(DivIters - 1)) begin
                  count_d = 6'd0;
                  state_d = StFix;
               end
            end
            StFix: begin
               if (op_b_q == 32'd0) begin
                  // Divide by zero returns all-ones quotient and the raw dividend.
                  lo_d = 32'hffff_ffff;
                  hi_d = op_a_q;
               end else begin
                  lo_d = neg_quo ? (~quo_q + 32'd1) : quo_q;
                  hi_d = neg_rem ? (~rem_q + 32'd1) : rem_q;
               end
               done_d  = 1'b1;
               state_d = StIdle;
            end
         endcase
      end
   end

   // State and datapath registers; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         func_q  <= FnSll;
         op_a_q  <= 32'd0;
         op_b_q  <= 32'd0;
         rem_q   <= 32'd0;
         quo_q   <= 32'd0;
         dvsr_q  <= 32'd0;
         count_q <= 6'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         func_q  <= func_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvsr_q  <= dvsr_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: inputs driven and outputs sampled on the falling edge.
module tb_muldiv_unit;
   import Func::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   Func_t       func;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   muldiv_unit dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .func   (func),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one start for a single cycle; returns at the falling edge after the accept edge.
   task automatic issue(input Func_t f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start  = 1'b1;
      func   = f;
      rs_val = a;
      rt_val = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Count falling edges with busy high (including the current one), bounded at 100.
   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #3;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
      checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mult;
      issue(FnMultu, 32'hffff_ffff, 32'hffff_ffff);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multu_busy: got %b want 1", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_early: got %b want 0", done); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_end: got %b want 0", busy); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL multu_done: got %b want 1", done); end
      checks++; if (hi !== 32'hffff_fffe) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
      checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b want 0", done); end

      issue(FnMult, 32'hffff_fffe, 32'h0000_0003);
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL mult_done: got %b want 1", done); end
      checks++; if (hi !== 32'hffff_ffff) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
      checks++; if (lo !== 32'hffff_fffa) begin errors++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
   endtask

   task automatic test_div;
      logic [31:0] hi_before;
      int n;
      hi_before = hi;
      issue(FnDiv, 32'hffff_fff9, 32'h0000_0002);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         // A start mid-operation must be ignored; an accepted MTHI would show up on hi.
         if (n == 9) begin
            start  = 1'b1;
            func   = FnMthi;
            rs_val = 32'hdead_beef;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
         if (n == 11) begin
            checks++;
            if (hi !== hi_before) begin
               errors++; $display("FAIL div_ignore_start: hi got %h want %h", hi, hi_before);
            end
         end
      end
      start = 1'b0;
      checks++; if (n != 33) begin errors++; $display("FAIL div_busy_cycles: got %0d want 33", n); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL div_done: got %b want 1", done); end
      checks++; if (lo !== 32'hffff_fffd) begin errors++; $display("FAIL div_lo: got %h want fffffffd", lo); end
      checks++; if (hi !== 32'hffff_ffff) begin errors++; $display("FAIL div_hi: got %h want ffffffff", hi); end
   endtask

   task automatic test_div_corners;
      int n;
      issue(FnDivu, 32'h0000_0064, 32'h0000_0000);
      wait_idle(n);
      checks++; if (n != 33) begin errors++; $display("FAIL divz_busy_cycles: got %0d want 33", n); end
      checks++; if (lo !== 32'hffff_ffff) begin errors++; $display("FAIL divz_lo: got %h want ffffffff", lo); end
      checks++; if (hi !== 32'h0000_0064) begin errors++; $display("FAIL divz_hi: got %h want 00000064", hi); end

      issue(FnDiv, 32'h8000_0000, 32'hffff_ffff);
      wait_idle(n);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL divovf_done: got %b want 1", done); end
      checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
      checks++; if (hi !== 32'h0000_0000) begin errors++; $display("FAIL divovf_hi: got %h want 0", hi); end

      issue(FnDiv, 32'h0000_0064, 32'hffff_fff9);
      wait_idle(n);
      checks++; if (lo !== 32'hffff_fff2) begin errors++; $display("FAIL divneg_lo: got %h want fffffff2", lo); end
      checks++; if (hi !== 32'h0000_0002) begin errors++; $display("FAIL divneg_hi: got %h want 00000002", hi); end
   endtask

   task automatic test_mthi_mtlo_noop;
      issue(FnMthi, 32'h1111_1111, 32'h0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", busy); end
      checks++; if (hi !== 32'h1111_1111) begin errors++; $display("FAIL mthi_hi: got %h want 11111111", hi); end
      issue(FnMtlo, 32'h2222_2222, 32'h0);
      checks++; if (lo !== 32'h2222_2222) begin errors++; $display("FAIL mtlo_lo: got %h want 22222222", lo); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL mtlo_done: got %b want 0", done); end
      issue(FnMfhi, 32'h3333_3333, 32'h4);
      issue(FnAdd, 32'h5555_5555, 32'h6);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noop_busy: got %b want 0", busy); end
      checks++; if (hi !== 32'h1111_1111) begin errors++; $display("FAIL noop_hi: got %h want 11111111", hi); end
      checks++; if (lo !== 32'h2222_2222) begin errors++; $display("FAIL noop_lo: got %h want 22222222", lo); end
   endtask

   task automatic test_flush;
      issue(FnDivu, 32'h0000_0010, 32'h0000_0003);
      // Now in busy cycle 1; advance to cycle 9, then hold flush through cycle 10.
      repeat (8) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done: got %b want 0", done); end
      repeat (40) begin
         @(negedge clk);
         if (done !== 1'b0) begin
            checks++; errors++; $display("FAIL flush_late_done: got %b want 0", done);
         end
      end
      checks++; if (hi !== 32'h1111_1111) begin errors++; $display("FAIL flush_hi: got %h want 11111111", hi); end
      checks++; if (lo !== 32'h2222_2222) begin errors++; $display("FAIL flush_lo: got %h want 22222222", lo); end

      // Same-cycle flush and start: nothing accepted.
      flush = 1'b1;
      issue(FnMthi, 32'haaaa_aaaa, 32'h0);
      flush = 1'b0;
      checks++; if (hi !== 32'h1111_1111) begin errors++; $display("FAIL flushstart_hi: got %h want 11111111", hi); end
      flush = 1'b1;
      issue(FnDiv, 32'h0000_0009, 32'h0000_0002);
      flush = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flushstart_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid_div;
      issue(FnDivu, 32'h0000_1234, 32'h0000_0005);
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rstmid_hi: got %h want 0", hi); end
      checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rstmid_lo: got %h want 0", lo); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rstmid_noresult: got %h want 0", lo); end
      issue(FnMultu, 32'h0000_0003, 32'h0000_0005);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_accept: got %b want 1", busy); end
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rstmid_done: got %b want 1", done); end
      checks++; if (lo !== 32'h0000_000f) begin errors++; $display("FAIL rstmid_lo2: got %h want 0000000f", lo); end
      checks++; if (hi !== 32'h0000_0000) begin errors++; $display("FAIL rstmid_hi2: got %h want 0", hi); end
   endtask

   initial begin
      start  = 1'b0;
      flush  = 1'b0;
      func   = FnSll;
      rs_val = 32'd0;
      rt_val = 32'd0;
      test_reset();
      test_mult();
      test_div();
      test_div_corners();
      test_mthi_mtlo_noop();
      test_flush();
      test_reset_mid_div();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
